// File: rtl/pipelined_rcs_subtractor_if.sv
// Handshake and data bundle for the pipelined ripple-chunk subtractor.
// The master side presents operands and drives out_ready; the slave side is the subtractor.
interface pipelined_rcs_subtractor_if #(
  parameter int unsigned BIT_WIDTH = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] min_in;
  logic [BIT_WIDTH-1:0] sub_in;
  logic                 b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] diff;
  logic                 b_out;
  logic                 ovf;

  modport master (
    output in_valid,
    output min_in,
    output sub_in,
    output b_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  b_out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  min_in,
    input  sub_in,
    input  b_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output b_out,
    output ovf
  );

endinterface

// File: rtl/pipelined_rcs_subtractor.sv
// Pipelined subtractor: each stage ripples the borrow through one CW-bit chunk and
// hands the operands, partial difference and borrow to the next stage with its transaction.
module pipelined_rcs_subtractor #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned STAGES    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  pipelined_rcs_subtractor_if.slave  bus
);

  localparam int unsigned CW  = BIT_WIDTH / STAGES;
  localparam int unsigned Msb = BIT_WIDTH - 1;
  localparam int unsigned Lst = STAGES - 1;

  // Per-stage state: the register of stage k holds its transaction after chunk k is resolved.
  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                borrow_q;
  logic [STAGES-1:0][BIT_WIDTH-1:0] min_q;
  logic [STAGES-1:0][BIT_WIDTH-1:0] sub_q;
  logic [STAGES-1:0][BIT_WIDTH-1:0] diff_q;

  // Inputs seen by each stage: the bus for stage 0, the previous stage register otherwise.
  logic [STAGES-1:0]                src_valid;
  logic [STAGES-1:0]                src_borrow;
  logic [STAGES-1:0][BIT_WIDTH-1:0] src_min;
  logic [STAGES-1:0][BIT_WIDTH-1:0] src_sub;
  logic [STAGES-1:0][BIT_WIDTH-1:0] src_diff;

  logic [STAGES-1:0]                borrow_d;
  logic [STAGES-1:0][BIT_WIDTH-1:0] diff_d;

  logic en;
  logic bit_a;
  logic bit_b;
  logic bit_bw;

  // The whole pipe moves as one; it only stalls when a finished result is not taken.
  assign en = !valid_q[Lst] || bus.out_ready;

  always_comb begin
    src_valid[0]  = bus.in_valid;
    src_borrow[0] = bus.b_in;
    src_min[0]    = bus.min_in;
    src_sub[0]    = bus.sub_in;
    src_diff[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k]  = valid_q[k-1];
      src_borrow[k] = borrow_q[k-1];
      src_min[k]    = min_q[k-1];
      src_sub[k]    = sub_q[k-1];
      src_diff[k]   = diff_q[k-1];
    end
  end

  // Ripple-borrow chain of CW one-bit full subtractors per stage.
  always_comb begin
    diff_d   = src_diff;
    borrow_d = '0;
    bit_a    = 1'b0;
    bit_b    = 1'b0;
    bit_bw   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      bit_bw = src_borrow[k];
      for (int i = 0; i < CW; i++) begin
        bit_a = src_min[k][k*CW + i];
        bit_b = src_sub[k][k*CW + i];
        diff_d[k][k*CW + i] = bit_a ^ bit_b ^ bit_bw;
        bit_bw = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bit_bw);
      end
      borrow_d[k] = bit_bw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      borrow_q <= '0;
      min_q    <= '0;
      sub_q    <= '0;
      diff_q   <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= src_valid[k];
        // Bubbles leave data untouched so the outputs never pick up undriven inputs.
        if (src_valid[k]) begin
          borrow_q[k] <= borrow_d[k];
          min_q[k]    <= src_min[k];
          sub_q[k]    <= src_sub[k];
          diff_q[k]   <= diff_d[k];
        end
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[Lst];
  assign bus.diff      = diff_q[Lst];
  assign bus.b_out     = borrow_q[Lst];
  assign bus.ovf       = (min_q[Lst][Msb] != sub_q[Lst][Msb]) &&
                         (diff_q[Lst][Msb] != min_q[Lst][Msb]);

endmodule

// File: tb/tb_pipelined_rcs_subtractor.sv
// Directed and randomized checks of the pipelined subtractor at BIT_WIDTH=16, STAGES=4.
module tb_pipelined_rcs_subtractor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipelined_rcs_subtractor_if #(.BIT_WIDTH(16)) bif ();

  pipelined_rcs_subtractor #(
    .BIT_WIDTH (16),
    .STAGES    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bif.in_valid  = 1'b1;
    bif.min_in    = 16'hFFFF;
    bif.sub_in    = 16'h0000;
    bif.b_in      = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid);
    end
    checks++;
    if (bif.diff !== 16'h0000) begin
      failures++;
      $display("FAIL reset_diff: got %h expected 0000", bif.diff);
    end
    checks++;
    if (bif.b_out !== 1'b0 || bif.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got b_out=%b ovf=%b expected 0 0", bif.b_out, bif.ovf);
    end
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready);
    end
    rst          = 1'b0;
    bif.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bif.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_discard cycle %0d: got out_valid=%b expected 0", i, bif.out_valid);
      end
    end
  endtask

  task automatic run_single(input string name, input logic [15:0] m, input logic [15:0] s,
                            input logic bin, input logic [15:0] ed, input logic eb,
                            input logic eo);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.min_in    = m;
    bif.sub_in    = s;
    bif.b_in      = bin;
    #1;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready: got %b expected 1", name, bif.in_ready);
    end
    tick();
    bif.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bif.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_early: got out_valid=%b expected 0 after edge %0d", name,
                 bif.out_valid, i + 2);
      end
    end
    tick();
    checks++;
    if (bif.out_valid !== 1'b1 || bif.diff !== ed || bif.b_out !== eb || bif.ovf !== eo) begin
      failures++;
      $display("FAIL %s: got v=%b diff=%h b_out=%b ovf=%b expected v=1 diff=%h b_out=%b ovf=%b",
               name, bif.out_valid, bif.diff, bif.b_out, bif.ovf, ed, eb, eo);
    end
    tick();
    checks++;
    if (bif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_one_cycle: got out_valid=%b expected 0", name, bif.out_valid);
    end
  endtask

  task automatic test_vectors();
    run_single("basic",      16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_single("ripple",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_single("ovf_neg",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_single("borrow_in",  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_single("ovf_pos",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_single("max_bin",    16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] m_t [8];
    logic [15:0] s_t [8];
    logic        b_t [8];
    logic [15:0] d_t [8];
    logic        bo_t[8];
    logic        o_t [8];
    logic [15:0] hd;
    logic        hb;
    logic        ho;
    logic        held;
    logic        exp_ir;
    int          sent;
    int          recv;
    int          cyc;
    int          stalls;
    m_t = '{16'h0010, 16'h0100, 16'h1000, 16'h0001, 16'h8000, 16'h7FFF, 16'hABCD, 16'h5555};
    s_t = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h8000, 16'h8000, 16'h1234, 16'hAAAA};
    b_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    d_t = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h9999, 16'hAAAA};
    bo_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    o_t  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0;
    recv = 0;
    cyc = 0;
    stalls = 0;
    held = 1'b0;
    hd = '0;
    hb = 1'b0;
    ho = 1'b0;
    while (recv < 8 && cyc < 60) begin
      bif.out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        bif.in_valid = 1'b1;
        bif.min_in   = m_t[sent];
        bif.sub_in   = s_t[sent];
        bif.b_in     = b_t[sent];
      end else begin
        bif.in_valid = 1'b0;
      end
      #1;
      exp_ir = !(bif.out_valid && !bif.out_ready);
      checks++;
      if (bif.in_ready !== exp_ir) begin
        failures++;
        $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", cyc, bif.in_ready, exp_ir);
      end
      if (bif.in_ready === 1'b0) stalls++;
      if (held) begin
        checks++;
        if (bif.out_valid !== 1'b1 || bif.diff !== hd || bif.b_out !== hb || bif.ovf !== ho) begin
          failures++;
          $display("FAIL b2b_hold cycle %0d: got v=%b diff=%h b_out=%b ovf=%b expected v=1 %h %b %b",
                   cyc, bif.out_valid, bif.diff, bif.b_out, bif.ovf, hd, hb, ho);
        end
      end
      held = bif.out_valid && !bif.out_ready;
      hd = bif.diff;
      hb = bif.b_out;
      ho = bif.ovf;
      if (bif.out_valid && bif.out_ready) begin
        checks++;
        if (bif.diff !== d_t[recv] || bif.b_out !== bo_t[recv] || bif.ovf !== o_t[recv]) begin
          failures++;
          $display("FAIL b2b_result %0d: got diff=%h b_out=%b ovf=%b expected %h %b %b", recv,
                   bif.diff, bif.b_out, bif.ovf, d_t[recv], bo_t[recv], o_t[recv]);
        end
        recv++;
      end
      if (bif.in_valid && bif.in_ready) sent++;
      tick();
      cyc++;
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    checks++;
    if (recv != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected 8", recv);
    end
    checks++;
    if (stalls != 3) begin
      failures++;
      $display("FAIL b2b_stall_cycles: got %0d expected 3", stalls);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.min_in    = 16'h1111;
    bif.sub_in    = 16'h0001;
    bif.b_in      = 1'b0;
    tick();
    bif.min_in = 16'h2222;
    bif.sub_in = 16'h0002;
    tick();
    bif.in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bif.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_hold %0d: got out_valid=%b expected 0", i, bif.out_valid);
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bif.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_discard %0d: got out_valid=%b expected 0", i, bif.out_valid);
      end
    end
    run_single("after_reset", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [17:0] q[$];
    logic [17:0] exp_v;
    logic [16:0] full;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < N && cyc < 40000) begin
      bif.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < N && $urandom_range(0, 3) != 0) begin
        bif.in_valid = 1'b1;
        bif.min_in   = 16'($urandom);
        bif.sub_in   = 16'($urandom);
        bif.b_in     = 1'($urandom_range(0, 1));
      end else begin
        bif.in_valid = 1'b0;
      end
      #1;
      if (bif.out_valid && bif.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious: got result %h with no pending transaction", bif.diff);
        end else begin
          exp_v = q.pop_front();
          if ({bif.b_out, bif.ovf, bif.diff} !== exp_v) begin
            failures++;
            $display("FAIL rand_result %0d: got b_out=%b ovf=%b diff=%h expected %b %b %h",
                     recv, bif.b_out, bif.ovf, bif.diff, exp_v[17], exp_v[16], exp_v[15:0]);
          end
        end
        recv++;
      end
      if (bif.in_valid && bif.in_ready) begin
        full = {1'b0, bif.min_in} - {1'b0, bif.sub_in} - {16'h0000, bif.b_in};
        q.push_back({full[16],
                     (bif.min_in[15] != bif.sub_in[15]) && (full[15] != bif.min_in[15]),
                     full[15:0]});
        sent++;
      end
      tick();
      cyc++;
    end
    bif.in_valid = 1'b0;
    checks++;
    if (recv != N || q.size() != 0) begin
      failures++;
      $display("FAIL rand_count: got %0d results with %0d pending expected %0d with 0 pending",
               recv, q.size(), N);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.min_in    = '0;
    bif.sub_in    = '0;
    bif.b_in      = 1'b0;
    bif.out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_rcs_subtractor.md
PIPELINED_RCS_SUBTRACTOR -- requirements
Module: pipelined_rcs_subtractor

Interface
REQ-001 Parameter BIT_WIDTH, default 16: operand and difference width.
REQ-002 Parameter STAGES, default 4: pipeline depth; BIT_WIDTH divisible by STAGES; chunk width CW = BIT_WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands presented this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 min_in  input  BIT_WIDTH  minuend, unsigned / two's complement.
REQ-008 sub_in  input  BIT_WIDTH  subtrahend.
REQ-009 b_in  input  1  borrow-in, subtracted at bit 0.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 diff  output  BIT_WIDTH  min_in - sub_in - b_in, modulo 2^BIT_WIDTH.
REQ-013 b_out  output  1  borrow-out: 1 when unsigned min_in < sub_in + b_in.
REQ-014 ovf  output  1  signed overflow of the two's-complement difference.

Function
REQ-015 Datapath: STAGES register stages; stage k (0..STAGES-1) resolves difference bits [k*CW+CW-1 : k*CW] through a ripple-borrow chain of CW one-bit full subtractors.
REQ-016 Borrow into stage 0 is b_in; borrow into stage k>0 is the registered borrow-out of stage k-1 for the same transaction.
REQ-017 Not-yet-consumed operand chunks and already-resolved difference chunks travel with their transaction in per-stage registers; no transaction mixes chunks from another.
REQ-018 Each stage holds a valid bit; transaction accepted when in_valid && in_ready.
REQ-019 Advance enable en = !out_valid || out_ready; when en=1 all stages shift one position; when en=0 all stage registers hold.
REQ-020 in_ready = en, combinational; no combinational path from in_valid to in_ready.
REQ-021 Latency: accepted at edge N with no stall -> out_valid=1 with result after edge N+STAGES-1 (visible in cycle N+STAGES... i.e. STAGES edges including acceptance edge).
REQ-022 Throughput: one transaction per cycle with out_ready held 1; bubbles (in_valid=0) propagate as invalid stages.
REQ-023 diff, b_out, ovf held stable while out_valid=1 and out_ready=0.
REQ-024 b_out = final-stage borrow-out; ovf = (min_in[MSB] != sub_in[MSB]) && (diff[MSB] != min_in[MSB]); MSB sign bits carried to final stage for this.
REQ-025 In-flight transactions leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-026 Simultaneous accept and output handshake in one cycle legal; both take effect at same edge.
REQ-027 diff, b_out, ovf value when out_valid=0: don't-care for consumers, but shall not be X after reset.

Reset
REQ-028 rst=1 at an edge clears all stage valid bits and data registers to 0: out_valid=0, diff=0, b_out=0, ovf=0.
REQ-029 in_ready=1 during and after reset (en=1 since out_valid=0); inputs sampled during a reset cycle are discarded.
REQ-030 Reset mid-operation discards every in-flight transaction; first out_valid after release belongs to a transaction accepted after release.

Verification (BIT_WIDTH=16, STAGES=4)
REQ-031 min_in=0x1234, sub_in=0x0234, b_in=0, out_ready=1 -> 4 edges later diff=0x1000, b_out=0, ovf=0, out_valid=1 for one cycle.
REQ-032 min_in=0x0000, sub_in=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0 (borrow ripples across all 4 stages).
REQ-033 min_in=0x8000, sub_in=0x0001, b_in=0 -> diff=0x7FFF, b_out=0, ovf=1; min_in=0x0005, sub_in=0x0005, b_in=1 -> diff=0xFFFF, b_out=1, ovf=0.
REQ-034 Back-to-back stream of 8 operand pairs with out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready, outputs held stable, all 8 results correct and in order.
REQ-035 rst asserted 2 cycles after accepting 2 transactions -> out_valid=0 through reset, neither transaction appears; next accepted pair produces correct result after 4 edges.
REQ-036 Random constrained stimulus (random in_valid/out_ready, 10k transactions) -> every result equals reference model of min_in - sub_in - b_in with matching b_out and ovf.
